mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 136 +++++++++++++
 tb/tb_mac_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Buffers up to eight 8-bit operand pairs and sequences them through an external
// handshaked 8x8 multiplier, accumulating the products into a 20-bit sum.
module mac_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  a_data,
    input  logic [7:0]  b_data,
    input  logic        start,
    output logic        mul_go,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic        mul_done,
    input  logic [15:0] mul_p,
    output logic [19:0] acc,
    output logic        valid,
    output logic        busy,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RELEASE, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q, count_d;
    logic [19:0] acc_q, acc_d;
    logic        mul_go_q, mul_go_d;
    logic [7:0]  mul_a_q, mul_a_d;
    logic [7:0]  mul_b_q, mul_b_d;
    logic        valid_q, valid_d;
    logic        wr_en;
    logic [15:0] mem_q [8];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mul_go_d = mul_go_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        valid_d  = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load && !full) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 3'd1;
                    count_d  = count_q + 4'd1;
                end
                // start sees the count including a load in the same cycle
                if (start && (count_d != 4'd0)) begin
                    acc_d   = 20'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mul_a_d  = mem_q[rd_ptr_q][15:8];
                mul_b_d  = mem_q[rd_ptr_q][7:0];
                mul_go_d = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    acc_d    = acc_q + {4'd0, mul_p};
                    rd_ptr_d = rd_ptr_q + 3'd1;
                    count_d  = count_q - 4'd1;
                    mul_go_d = 1'b0;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                // a lingering done must not be counted again
                if (!mul_done) begin
                    if (count_q == 4'd0) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                wr_ptr_d = 3'd0;
                rd_ptr_d = 3'd0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            count_q  <= 4'd0;
            acc_q    <= 20'd0;
            mul_go_q <= 1'b0;
            mul_a_q  <= 8'd0;
            mul_b_q  <= 8'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mul_go_q <= mul_go_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= {a_data, b_data};
        end
    end

    assign mul_go = mul_go_q;
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign acc    = acc_q;
    assign valid  = valid_q;
    assign busy   = (state_q != IDLE);
    assign count  = count_q;
    assign full   = (count_q == 4'd8);
    assign empty  = (count_q == 4'd0);

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: a vector table, directed handshake
// sequences and randomized jobs checked against a queue-based reference model.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [7:0]  a_data = 8'd0;
    logic [7:0]  b_data = 8'd0;
    logic        start = 1'b0;
    logic        mul_go;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_done = 1'b0;
    logic [15:0] mul_p = 16'd0;
    logic [19:0] acc;
    logic        valid;
    logic        busy;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    mac_sequencer dut (
        .clk(clk), .rst(rst), .load(load), .a_data(a_data), .b_data(b_data),
        .start(start), .mul_go(mul_go), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p), .acc(acc), .valid(valid),
        .busy(busy), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the pairs the buffer should hold, in order.
    logic [15:0] ref_q[$];

    // Multiplier model: raises done mul_lat cycles after go, holds it mul_hold
    // extra cycles after go drops.
    int mul_lat  = 2;
    int mul_hold = 0;
    int go_cnt   = 0;
    int hold_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            mul_done = 1'b0;
            go_cnt   = 0;
            hold_cnt = 0;
        end else if (mul_done) begin
            if (!mul_go) begin
                if (hold_cnt >= mul_hold) begin
                    mul_done = 1'b0;
                    hold_cnt = 0;
                end else begin
                    hold_cnt++;
                end
            end
        end else if (mul_go) begin
            go_cnt++;
            if (go_cnt >= mul_lat) begin
                mul_done = 1'b1;
                mul_p    = 16'(mul_a) * 16'(mul_b);
                go_cnt   = 0;
                hold_cnt = 0;
            end
        end else begin
            go_cnt = 0;
        end
    end

    // Handshake monitor: operands issued, go protocol errors, valid cycles.
    logic        done_at_edge = 1'b0;
    logic        rst_at_edge  = 1'b0;
    logic        prev_go      = 1'b0;
    logic [15:0] prev_ab      = 16'd0;
    logic [15:0] seen_q[$];
    int          go_rises  = 0;
    int          go_errs   = 0;
    int          valid_cnt = 0;

    always @(posedge clk) begin
        done_at_edge <= mul_done;
        rst_at_edge  <= rst;
    end

    always @(negedge clk) begin
        if (mul_go && !prev_go) begin
            go_rises++;
            seen_q.push_back({mul_a, mul_b});
            if (done_at_edge) go_errs++;
        end
        if (mul_go && prev_go && ({mul_a, mul_b} != prev_ab)) go_errs++;
        if (!mul_go && prev_go && !done_at_edge && !rst_at_edge) go_errs++;
        if (valid) valid_cnt++;
        prev_go = mul_go;
        prev_ab = {mul_a, mul_b};
    end

    typedef struct {
        logic       rst;
        logic       load;
        logic       start;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] exp_count;
        logic       exp_busy;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic l, input logic s,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] c, input logic bz,
                                input logic f, input logic e);
        vec_t v;
        v.rst = r; v.load = l; v.start = s; v.a = a; v.b = b;
        v.exp_count = c; v.exp_busy = bz; v.exp_full = f; v.exp_empty = e;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        rst = v.rst; load = v.load; start = v.start; a_data = v.a; b_data = v.b;
        @(posedge clk);
        #1;
        rst = 1'b0; load = 1'b0; start = 1'b0;
        if (v.rst) ref_q.delete();
        else if (v.load && ref_q.size() < 8) ref_q.push_back({v.a, v.b});
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        ref_q.delete();
    endtask

    task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        load = 1'b1; a_data = a; b_data = b;
        @(posedge clk);
        #1;
        load = 1'b0;
        if (ref_q.size() < 8) ref_q.push_back({a, b});
    endtask

    // Runs one accumulate job and checks its result against the model queue.
    task automatic run_job(input string tag, input logic with_load,
                           input logic [7:0] a, input logic [7:0] b, input int budget);
        int v0, g0, e0, b0, cyc, n, sum, bad;
        v0 = valid_cnt; g0 = go_rises; e0 = go_errs; b0 = seen_q.size();
        @(negedge clk);
        start = 1'b1;
        load = with_load; a_data = a; b_data = b;
        @(posedge clk);
        #1;
        start = 1'b0; load = 1'b0;
        if (with_load && ref_q.size() < 8) ref_q.push_back({a, b});
        check_output({tag, " busy after start"}, 32'(busy), 32'd1);
        cyc = 0;
        while (valid_cnt == v0 && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_output({tag, " valid within budget"}, 32'(cyc < budget), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        n = ref_q.size();
        sum = 0;
        bad = 0;
        foreach (ref_q[i]) begin
            sum += int'(ref_q[i][15:8]) * int'(ref_q[i][7:0]);
            if (b0 + i >= seen_q.size() || seen_q[b0 + i] != ref_q[i]) bad++;
        end
        check_output({tag, " acc"}, 32'(acc), 32'(sum));
        check_output({tag, " valid cycles"}, 32'(valid_cnt - v0), 32'd1);
        check_output({tag, " go pulses"}, 32'(go_rises - g0), 32'(n));
        check_output({tag, " operand order errors"}, 32'(bad), 32'd0);
        check_output({tag, " go protocol errors"}, 32'(go_errs - e0), 32'd0);
        check_output({tag, " count after"}, 32'(count), 32'd0);
        check_output({tag, " empty after"}, 32'(empty), 32'd1);
        check_output({tag, " busy after"}, 32'(busy), 32'd0);
        ref_q.delete();
    endtask

    task automatic run_empty(input string tag);
        int v0, g0, bsy;
        v0 = valid_cnt; g0 = go_rises; bsy = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) begin
            if (busy) bsy++;
            @(posedge clk);
            #1;
        end
        check_output({tag, " busy cycles"}, 32'(bsy), 32'd0);
        check_output({tag, " go pulses"}, 32'(go_rises - g0), 32'd0);
        check_output({tag, " valid cycles"}, 32'(valid_cnt - v0), 32'd0);
    endtask

    initial begin
        int v0, g0, cyc, n;

        // Reset, empty start, then nine loads of (255,255) with the ninth ignored.
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 1));
        for (int k = 1; k <= 9; k++)
            vecs.push_back(mk(0, 1, 0, 8'd255, 8'd255, (k > 8) ? 4'd8 : 4'(k),
                              0, k >= 8, 0));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check_output($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check_output($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].exp_full));
            check_output($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            check_output($sformatf("vec%0d acc", i), 32'(acc), 32'd0);
            check_output($sformatf("vec%0d mul_go", i), 32'(mul_go), 32'd0);
            check_output($sformatf("vec%0d valid", i), 32'(valid), 32'd0);
        end

        mul_lat = 2; mul_hold = 0;
        run_job("full8", 1'b0, 8'd0, 8'd0, 300);
        check_output("full8 acc max", 32'(acc), 32'd520200);

        mul_lat = 4; mul_hold = 0;
        load_pair(8'd2, 8'd2);
        run_job("pair2x2", 1'b0, 8'd0, 8'd0, 100);
        check_output("pair2x2 acc", 32'(acc), 32'd4);
        check_output("pair2x2 mul_a", 32'(mul_a), 32'd2);
        check_output("pair2x2 mul_b", 32'(mul_b), 32'd2);

        mul_lat = 2; mul_hold = 3;
        load_pair(8'd3, 8'd5);
        load_pair(8'd7, 8'd9);
        run_job("longdone", 1'b0, 8'd0, 8'd0, 100);
        check_output("longdone acc", 32'(acc), 32'd78);

        mul_lat = 1; mul_hold = 0;
        run_job("loadstart", 1'b1, 8'd6, 8'd7, 100);
        check_output("loadstart acc", 32'(acc), 32'd42);

        run_empty("emptystart");

        // Reset while the second pair is waiting on the multiplier.
        mul_lat = 4; mul_hold = 0;
        load_pair(8'd10, 8'd11);
        load_pair(8'd12, 8'd13);
        load_pair(8'd14, 8'd15);
        v0 = valid_cnt; g0 = go_rises;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (go_rises - g0 < 2 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_output("midrst reached 2nd WAIT", 32'(cyc < 100), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_q.delete();
        check_output("midrst mul_go", 32'(mul_go), 32'd0);
        check_output("midrst busy", 32'(busy), 32'd0);
        check_output("midrst acc", 32'(acc), 32'd0);
        check_output("midrst count", 32'(count), 32'd0);
        check_output("midrst empty", 32'(empty), 32'd1);
        repeat (10) @(negedge clk);
        #1;
        check_output("midrst valid cycles", 32'(valid_cnt - v0), 32'd0);

        // Randomized jobs against the reference queue.
        for (int r = 0; r < 12; r++) begin
            mul_lat  = $urandom_range(1, 5);
            mul_hold = $urandom_range(0, 3);
            n = $urandom_range(0, 10);
            for (int k = 0; k < n; k++)
                load_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            check_output($sformatf("rnd%0d count", r), 32'(count), 32'(ref_q.size()));
            check_output($sformatf("rnd%0d full", r), 32'(full), 32'(ref_q.size() == 8));
            check_output($sformatf("rnd%0d empty", r), 32'(empty), 32'(ref_q.size() == 0));
            if (ref_q.size() == 0) run_empty($sformatf("rnd%0d", r));
            else run_job($sformatf("rnd%0d", r), 1'b0, 8'd0, 8'd0, 300);
        end

        do_reset(2);
        check_output("final reset count", 32'(count), 32'd0);
        check_output("final reset acc", 32'(acc), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
